// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF fetch and MEM load/store, data first
// Optional stall-cycle statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_dmtype,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_dmtype,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [31:0]       stat_if_wait,
  output logic [31:0]       stat_d_wait
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        dmtype_q, dmtype_d;
  logic              fetch_forced;
  logic              in_gnt;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    dmtype_d     = dmtype_q;
    fetch_forced = if_req && (starve_cnt_q == STARVE_LIM);
    case (state_q)
      IDLE: begin
        if (!if_req) starve_cnt_d = '0;
        if (d_req && !fetch_forced) begin
          state_d  = GNT_D;
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          dmtype_d = d_dmtype;
        end else if (if_req) begin
          state_d  = GNT_I;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          dmtype_d = 3'b010;
        end
      end
      GNT_I: begin
        if (mem_ack) begin
          state_d      = IDLE;
          starve_cnt_d = '0;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          state_d = IDLE;
          // count only data wins that kept a fetch waiting
          if (if_req && (starve_cnt_q != STARVE_LIM)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      dmtype_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      dmtype_q     <= dmtype_d;
    end
  end

  assign in_gnt     = (state_q != IDLE);
  assign mem_req    = in_gnt;
  assign mem_we     = in_gnt && we_q;
  assign mem_addr   = in_gnt ? addr_q : '0;
  assign mem_wdata  = in_gnt ? wdata_q : '0;
  assign mem_dmtype = in_gnt ? dmtype_q : 3'b000;

  assign if_ready = (state_q == GNT_I) && mem_ack;
  assign d_ready  = (state_q == GNT_D) && mem_ack;
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign d_rdata  = (d_ready && !we_q) ? mem_rdata : '0;

  // stalls are forced low while reset is held so every output reads 0
  assign stall_if  = rst && if_req && !if_ready;
  assign stall_mem = rst && d_req && !d_ready;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_wait_q, stat_if_wait_d;
  logic [31:0] stat_d_wait_q, stat_d_wait_d;

  always_comb begin
    stat_if_wait_d = stat_if_wait_q + 32'(stall_if);
    stat_d_wait_d  = stat_d_wait_q + 32'(stall_mem);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_if_wait_q <= '0;
      stat_d_wait_q  <= '0;
    end else begin
      stat_if_wait_q <= stat_if_wait_d;
      stat_d_wait_q  <= stat_d_wait_d;
    end
  end

  assign stat_if_wait = stat_if_wait_q;
  assign stat_d_wait  = stat_d_wait_q;
`else
  assign stat_if_wait = '0;
  assign stat_d_wait  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a transaction-level memory model
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk, rst;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  d_dmtype;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, stat_if_wait, stat_d_wait;
  logic        if_ready, d_ready, mem_req, mem_we, stall_if, stall_mem;
  logic [2:0]  mem_dmtype;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_dmtype(d_dmtype),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dmtype(mem_dmtype), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .stat_if_wait(stat_if_wait), .stat_d_wait(stat_d_wait)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
    logic [31:0] rdata;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  byte         grant_log[$];
  logic [31:0] mem_arr [0:127];
  logic [31:0] ref_arr [0:127];
  int          total = 0;
  int          bad = 0;
  int          lat_fixed = 0;
  int          mdl_if_wait = 0;
  int          mdl_d_wait = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic void push_if(input logic [31:0] a);
    exp_t e;
    e.addr = a; e.we = 1'b0; e.wdata = '0; e.dmtype = 3'b010;
    e.rdata = ref_arr[a[8:2]];
    if_q.push_back(e);
  endfunction

  function automatic void push_d(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                 input logic [2:0] dt);
    exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.dmtype = dt;
    if (we) begin
      ref_arr[a[8:2]] = wd;
      e.rdata = '0;
    end else begin
      e.rdata = ref_arr[a[8:2]];
    end
    d_q.push_back(e);
  endfunction

  // memory device: fixed or random latency, spurious acks while idle in random mode
  initial begin
    int  need, waited;
    bit  busy;
    mem_ack = 1'b0; mem_rdata = '0; busy = 0; need = 0; waited = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!rst) begin
        busy = 0;
      end else if (!mem_req) begin
        busy = 0;
        mem_ack = (lat_fixed < 0) && ($urandom_range(0, 7) == 0);
      end else begin
        if (!busy) begin
          busy = 1; waited = 0;
          need = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        end
        if (waited == need) begin
          mem_ack = 1'b1; busy = 0;
          if (mem_we) mem_arr[mem_addr[8:2]] = mem_wdata;
          else mem_rdata = mem_arr[mem_addr[8:2]];
        end else begin
          waited++;
        end
      end
    end
  end

  // monitor: grant order, grant fields, completions, stalls, stall-count model
  initial begin
    bit   prev_req, prev_if, prev_d, prev_rdy, is_d, exp_d;
    int   consec;
    exp_t e;
    prev_req = 0; prev_if = 0; prev_d = 0; prev_rdy = 0; consec = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        prev_req = 0; prev_if = 0; prev_d = 0; prev_rdy = 0; consec = 0;
        mdl_if_wait = 0; mdl_d_wait = 0;
      end else begin
        if (prev_rdy) chk("bubble", 96'(mem_req), 96'(0));
        if (mem_req && !prev_req) begin
          is_d = (mem_addr >= 32'h100);
          grant_log.push_back(is_d ? 8'h44 : 8'h49);
          if (prev_if && prev_d) begin
            exp_d = (consec != SMAX);
            chk("arb_pick", 96'(is_d), 96'(exp_d));
          end
          if (is_d) begin
            chk("d_grant_q", 96'(d_q.size() > 0), 96'(1));
            if (d_q.size() > 0)
              chk("d_grant_fields", {mem_addr, mem_we, mem_wdata, mem_dmtype},
                  {d_q[0].addr, d_q[0].we, d_q[0].wdata, d_q[0].dmtype});
          end else begin
            chk("if_grant_q", 96'(if_q.size() > 0), 96'(1));
            if (if_q.size() > 0)
              chk("if_grant_fields", {mem_addr, mem_we, mem_wdata, mem_dmtype},
                  {if_q[0].addr, 1'b0, 32'h0, 3'b010});
          end
        end
        if (if_ready) begin
          chk("if_ready_q", 96'(if_q.size() > 0), 96'(1));
          if (if_q.size() > 0) begin
            e = if_q.pop_front();
            chk("if_rdata", 96'(if_rdata), 96'(e.rdata));
          end
        end else begin
          chk("if_rdata_idle", 96'(if_rdata), 96'(0));
        end
        if (d_ready) begin
          chk("d_ready_q", 96'(d_q.size() > 0), 96'(1));
          if (d_q.size() > 0) begin
            e = d_q.pop_front();
            chk("d_rdata", 96'(d_rdata), 96'(e.rdata));
          end
        end else begin
          chk("d_rdata_idle", 96'(d_rdata), 96'(0));
        end
        chk("stall_if", 96'(stall_if), 96'(if_req && !if_ready));
        chk("stall_mem", 96'(stall_mem), 96'(d_req && !d_ready));
        if (if_req && !if_ready) mdl_if_wait++;
        if (d_req && !d_ready) mdl_d_wait++;
        if (d_ready && if_req && consec < SMAX) consec++;
        if (if_ready) consec = 0;
        if (!mem_req && !if_req) consec = 0;
        prev_req = mem_req; prev_if = if_req; prev_d = d_req;
        prev_rdy = if_ready || d_ready;
      end
    end
  end

  task automatic fetch_stream(input int n, input bit gaps);
    int w;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        if_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if_req = 1'b1;
      push_if(if_addr);
      w = 0; #2;
      while (!if_ready && w < 40) begin @(negedge clk); #2; w++; end
      chk("if_done", 96'(if_ready), 96'(1));
    end
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic data_stream(input int n, input bit gaps, input bit allow_st);
    int w;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        d_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      d_addr   = {23'h0, 1'b1, 6'($urandom_range(0, 63)), 2'b00};
      d_we     = allow_st ? 1'($urandom_range(0, 1)) : 1'b0;
      d_wdata  = $urandom;
      d_dmtype = 3'($urandom_range(0, 7));
      d_req    = 1'b1;
      push_d(d_addr, d_we, d_wdata, d_dmtype);
      w = 0; #2;
      while (!d_ready && w < 40) begin @(negedge clk); #2; w++; end
      chk("d_done", 96'(d_ready), 96'(1));
    end
    @(negedge clk);
    d_req = 1'b0;
  endtask

  initial begin
    logic [31:0] base;
    logic [63:0] got_seq, exp_seq;
    int          st_cnt, rdy_cnt, w;
    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = $urandom;
      ref_arr[i] = mem_arr[i];
    end
    mem_arr[4]  = 32'h0050_0093; ref_arr[4]  = 32'h0050_0093;
    mem_arr[65] = 32'h1234_5678; ref_arr[65] = 32'h1234_5678;
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h4; d_addr = 32'h104; d_wdata = 32'hFFFF_FFFF; d_dmtype = 3'b111;

    // reset state with requests asserted
    repeat (2) @(negedge clk);
    #2;
    chk("rst_mem_req", 96'(mem_req), 96'(0));
    chk("rst_mem_addr", 96'(mem_addr), 96'(0));
    chk("rst_stall_if", 96'(stall_if), 96'(0));
    chk("rst_stall_mem", 96'(stall_mem), 96'(0));
    chk("rst_stat_d", 96'(stat_d_wait), 96'(0));
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; rst = 1'b1;
    @(negedge clk);

    // single zero-wait fetch
    lat_fixed = 0;
    @(negedge clk);
    if_addr = 32'h10; if_req = 1'b1; push_if(32'h10);
    #2;
    chk("f1_stall_t", 96'(stall_if), 96'(1));
    chk("f1_idle_t", 96'(mem_req), 96'(0));
    @(negedge clk); #2;
    chk("f1_addr", 96'(mem_addr), 96'(32'h10));
    chk("f1_ready", 96'(if_ready), 96'(1));
    chk("f1_rdata", 96'(if_rdata), 96'(32'h0050_0093));
    chk("f1_stall_t1", 96'(stall_if), 96'(0));
    @(negedge clk);
    if_req = 1'b0;

    // contention: store wins, fetch after one bubble
    @(negedge clk);
    lat_fixed = 2;
    if_addr = 32'h20; if_req = 1'b1; push_if(32'h20);
    d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_dmtype = 3'b010; d_req = 1'b1;
    push_d(32'h100, 1'b1, 32'hDEAD_BEEF, 3'b010);
    #2; chk("c_idle_t", 96'(mem_req), 96'(0));
    @(negedge clk); #2;
    chk("c_we", 96'(mem_we), 96'(1));
    chk("c_wdata", 96'(mem_wdata), 96'(32'hDEAD_BEEF));
    @(negedge clk); #2; chk("c_ready_t2", 96'(d_ready), 96'(0));
    @(negedge clk); #2; chk("c_ready_t3", 96'(d_ready), 96'(1));
    @(negedge clk); d_req = 1'b0; d_we = 1'b0;
    #2; chk("c_idle_t4", 96'(mem_req), 96'(0));
    @(negedge clk); #2;
    chk("c_fetch_t5", 96'(mem_req), 96'(1));
    chk("c_fetch_addr", 96'(mem_addr), 96'(32'h20));
    w = 0;
    while (!if_ready && w < 10) begin @(negedge clk); #2; w++; end
    chk("c_fetch_done", 96'(if_ready), 96'(1));
    @(negedge clk);
    if_req = 1'b0;

    // load with three wait cycles
    @(negedge clk);
    lat_fixed = 3;
    d_addr = 32'h104; d_we = 1'b0; d_dmtype = 3'b001; d_req = 1'b1;
    push_d(32'h104, 1'b0, d_wdata, 3'b001);
    base = stat_d_wait; st_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (c == 1) chk("l_dmtype", 96'(mem_dmtype), 96'(3'b001));
      st_cnt += int'(stall_mem);
      rdy_cnt += int'(d_ready);
      if (d_ready) chk("l_rdata", 96'(d_rdata), 96'(32'h1234_5678));
      @(negedge clk);
    end
    d_req = 1'b0;
    #2;
    chk("l_stall_cycles", 96'(st_cnt), 96'(4));
    chk("l_ready_pulses", 96'(rdy_cnt), 96'(1));
`ifdef MEM_ARB_STATS_EN
    chk("l_stat_d", 96'(stat_d_wait), 96'(base + 32'd4));
`else
    chk("l_stat_d", 96'(stat_d_wait), 96'(0));
`endif

    // starvation guard: four data wins, then the fetch
    lat_fixed = 0;
    grant_log.delete();
    fork
      fetch_stream(2, 1'b0);
      data_stream(6, 1'b0, 1'b0);
    join
    got_seq = '0;
    exp_seq = "DDDDIDDI";
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) got_seq = {got_seq[55:0], grant_log[i]};
    chk("starve_seq", 96'(got_seq), 96'(exp_seq));
    chk("starve_count", 96'(grant_log.size()), 96'(8));

    // reset in the middle of a data access
    @(negedge clk);
    lat_fixed = 6;
    d_addr = 32'h108; d_we = 1'b0; d_dmtype = 3'b010; d_req = 1'b1;
    push_d(32'h108, 1'b0, d_wdata, 3'b010);
    @(negedge clk); #2;
    chk("r_pre_req", 96'(mem_req), 96'(1));
    #1; rst = 1'b0; #1;
    chk("r_req_drop", 96'(mem_req), 96'(0));
    chk("r_addr_drop", 96'(mem_addr), 96'(0));
    chk("r_stall_mem", 96'(stall_mem), 96'(0));
    @(negedge clk);
    d_req = 1'b0; lat_fixed = 0; d_q.delete(); if_q.delete();
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clk);
    rst = 1'b1; push_if(32'h40);
    #2; chk("r_rel_idle", 96'(mem_req), 96'(0));
    @(negedge clk); #2;
    chk("r_fetch_req", 96'(mem_req), 96'(1));
    chk("r_fetch_addr", 96'(mem_addr), 96'(32'h40));
    chk("r_fetch_ready", 96'(if_ready), 96'(1));
    @(negedge clk);
    if_req = 1'b0;

    // randomized traffic with random latency and spurious idle acks
    lat_fixed = -1;
    fork
      fetch_stream(40, 1'b1);
      data_stream(40, 1'b1, 1'b1);
    join
    repeat (2) @(negedge clk);
    #3;
    chk("end_if_q", 96'(if_q.size()), 96'(0));
    chk("end_d_q", 96'(d_q.size()), 96'(0));
`ifdef MEM_ARB_STATS_EN
    chk("end_stat_if", 96'(stat_if_wait), 96'(32'(mdl_if_wait)));
    chk("end_stat_d", 96'(stat_d_wait), 96'(32'(mdl_d_wait)));
`else
    chk("end_stat_if", 96'(stat_if_wait), 96'(0));
    chk("end_stat_d", 96'(stat_d_wait), 96'(0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, single-port, variable-latency memory between two requesters of the 5-stage pipeline CPU: the IF-stage instruction fetch and the MEM-stage load/store.
- Sits between the CPU core and the memory wrapper.
- Generates per-stage stall signals that feed the hazard logic.
- Data port has priority; a starvation guard bounds instruction-fetch wait.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive data grants with fetch waiting before fetch is forced (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready
- if_ready  out  1  fetch completion pulse
- d_req  in  1  load/store request; held until d_ready
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_dmtype  in  3  access size/sign (DMType encoding)
- d_rdata  out  DATA_W  load data, valid when d_ready
- d_ready  out  1  data completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_dmtype  out  3  memory access type
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, ≥0 wait cycles after mem_req
- stall_if  out  1  fetch not complete this cycle
- stall_mem  out  1  data access not complete this cycle
- stat_if_wait  out  32  fetch stall cycle count (see Optional Feature)
- stat_d_wait  out  32  data stall cycle count (see Optional Feature)

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D.
- **Reset** (rst=0, asynchronous):
  - state=IDLE, starve_cnt=0, latched request registers=0.
  - All outputs 0.
  - An in-flight access is abandoned; mem_req drops immediately.
- **IDLE arbitration:**
  - d_req && !(if_req && starve_cnt==STARVE_MAX) → GNT_D.
  - else if_req → GNT_I.
  - else stay in IDLE.
- **Latching on grant:** the granted requester's addr/we/wdata/dmtype are registered on the IDLE→GNT edge. Fetch grants drive mem_we=0, mem_wdata=0 and mem_dmtype=3'b010 (word).
- **GNT_x:**
  - mem_req=1 and mem_* driven from the latched registers.
  - Stay until mem_ack, then return to IDLE. There is exactly one IDLE bubble between accesses.
- **Completion:** x_ready = (state==GNT_x) && mem_ack, combinational. x_rdata passes mem_rdata through when x_ready, else 0. d_rdata is 0 for stores.
- **Minimum latency:** request seen in IDLE at cycle t, memory acks in the first GNT cycle → ready at t+1.
- **Starvation counter (starve_cnt):**
  - Increments, saturating at STARVE_MAX, on each GNT_D completion while if_req=1.
  - Cleared on GNT_I completion.
  - Cleared on any cycle in IDLE with if_req=0.
- **Stalls:** stall_if = if_req && !if_ready; stall_mem = d_req && !d_ready. Both combinational.
- **Outside GNT states:** mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype all 0.
- **Requester dropping req while granted** (protocol violation): the access still completes on mem_ack; the ready pulse is still issued and is ignored.
- **mem_ack while in IDLE:** ignored.
- **Simultaneous d_req/if_req with starve_cnt<STARVE_MAX:** data wins.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- **Defined:** stat_if_wait and stat_d_wait are 32-bit counters.
  - Each increments by 1 on every cycle its stall_if/stall_mem is 1.
  - Both wrap from 0xFFFFFFFF to 0.
  - Both are reset to 0 by rst.
- **Undefined:** both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset mid-access: assert rst=0 in GNT_D with mem_req=1 → mem_req=0 same cycle; after release, state=IDLE and a pending if_req is granted next cycle.
- Single fetch, zero-wait: if_req=1, if_addr=0x0000_0010, mem_ack=1 with mem_rdata=0x0050_0093 in GNT cycle → mem_addr=0x10, if_ready=1, if_rdata=0x0050_0093 at t+1, stall_if=1 at t only.
- Contention: if_req and d_req (store, d_addr=0x100, d_wdata=0xDEAD_BEEF) rise together, memory 2 wait cycles → store granted first (mem_we=1, mem_wdata=0xDEADBEEF), d_ready at t+3, IDLE at t+4, fetch granted at t+5.
- Starvation, STARVE_MAX=4: d_req held high across 6 back-to-back loads with if_req high → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Load return: d_req, d_we=0, d_dmtype=3'b001, 3 wait cycles, mem_rdata=0x1234_5678 → mem_dmtype=3'b001, d_ready single-cycle pulse with d_rdata=0x12345678, stall_mem high for 4 cycles.
- MEM_ARB_STATS_EN defined: previous scenario → stat_d_wait=4; MEM_ARB_STATS_EN undefined → stat_d_wait stays 0.
